hive_stack_ring_p: RTL and testbench

Parametrised multi-thread LIFO bank: one BRAM holds THREADS independent stacks of DEPTH entries each, partitioned by thread ID. A per-thread level register file tracks the stacks. Each request carries its own thread ID, so back-to-back requests to the same thread are legal. Relative to the fixed 8-thread stack ring it adds:
- parametrised thread count, depth and width;
- simultaneous pop+push (replace);
- level readback;
- an optional non-destructive peek.

---
 rtl/hive_stack_ring_p.sv | 156 +++++++++++++++
 tb/tb_hive_stack_ring_p.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hive_stack_ring_p.sv
// ============================================================================
// hive_stack_ring_p : multi-thread LIFO bank, THREADS stacks in one BRAM.
// Optional peek enabled by defining HIVE_STK_PEEK_EN.      Revision: 1.0
// ============================================================================
`default_nettype none

module hive_stack_ring_p #(
  parameter int THREADS = 8,
  parameter int DEPTH   = 32,
  parameter int DATA_W  = 33,
  localparam int THD_W  = $clog2(THREADS),
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [THD_W-1:0]  id_i,
  input  logic              cls_i,
  input  logic              pop_i,
  input  logic              psh_i,
  input  logic              pek_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              vld_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              pop_er_o,
  output logic              psh_er_o
);

  localparam int AW = THD_W + PTR_W;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [LVL_W-1:0]  lvl_q [THREADS];
  logic [LVL_W-1:0]  lvl_d [THREADS];
  logic [LVL_W-1:0]  cur_lvl, nxt_lvl;
  logic [PTR_W-1:0]  top_ptr, rd_ptr, wr_ptr;
  logic              rd_en, wr_en;
  logic              pop_er_d, pop_er_q, psh_er_d, psh_er_q;
  logic [LVL_W-1:0]  level_d, level_q;
  logic              rd_vld_d, rd_vld_q;
  logic              vld_d, vld_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [DATA_W-1:0] mem [2**AW];
  logic [DATA_W-1:0] ram_rd_q;

`ifndef HIVE_STK_PEEK_EN
  logic unused_pek;
  assign unused_pek = pek_i;
`endif

  assign cur_lvl = lvl_q[id_i];
  // Valid whenever cur_lvl is 1..DEPTH; DEPTH wraps to 0 then decrements.
  assign top_ptr = cur_lvl[PTR_W-1:0] - PTR_W'(1);

  always_comb begin
    nxt_lvl  = cur_lvl;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    rd_ptr   = top_ptr;
    wr_ptr   = cur_lvl[PTR_W-1:0];
    pop_er_d = 1'b0;
    psh_er_d = 1'b0;
    if (cls_i) begin
      nxt_lvl = '0;
      if (psh_i) begin
        wr_en   = 1'b1;
        wr_ptr  = '0;
        nxt_lvl = LVL_W'(1);
      end
    end else if (pop_i && psh_i) begin
      if (cur_lvl != '0) begin
        rd_en  = 1'b1;
        wr_en  = 1'b1;
        wr_ptr = top_ptr;
      end else begin
        pop_er_d = 1'b1;
        wr_en    = 1'b1;
        wr_ptr   = '0;
        nxt_lvl  = LVL_W'(1);
      end
    end else if (pop_i) begin
      if (cur_lvl != '0) begin
        rd_en   = 1'b1;
        nxt_lvl = cur_lvl - LVL_W'(1);
      end else begin
        pop_er_d = 1'b1;
      end
    end else if (psh_i) begin
      if (cur_lvl != LVL_FULL) begin
        wr_en   = 1'b1;
        nxt_lvl = cur_lvl + LVL_W'(1);
      end else begin
        psh_er_d = 1'b1;
      end
    end
`ifdef HIVE_STK_PEEK_EN
    else if (pek_i) begin
      if (cur_lvl != '0) begin
        rd_en = 1'b1;
      end else begin
        pop_er_d = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    lvl_d        = lvl_q;
    lvl_d[id_i]  = nxt_lvl;
    level_d      = nxt_lvl;
    rd_vld_d     = rd_en;
    vld_d        = rd_vld_q;
    data_d       = rd_vld_q ? ram_rd_q : data_q;
  end

  // Read-before-write: a replace returns the old top from the same address.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[{id_i, wr_ptr}] <= data_i;
    end
    if (rd_en) begin
      ram_rd_q <= mem[{id_i, rd_ptr}];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int t = 0; t < THREADS; t++) begin
        lvl_q[t] <= '0;
      end
      level_q  <= '0;
      pop_er_q <= 1'b0;
      psh_er_q <= 1'b0;
      rd_vld_q <= 1'b0;
      vld_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      lvl_q    <= lvl_d;
      level_q  <= level_d;
      pop_er_q <= pop_er_d;
      psh_er_q <= psh_er_d;
      rd_vld_q <= rd_vld_d;
      vld_q    <= vld_d;
      data_q   <= data_d;
    end
  end

  assign data_o   = data_q;
  assign vld_o    = vld_q;
  assign level_o  = level_q;
  assign pop_er_o = pop_er_q;
  assign psh_er_o = psh_er_q;

endmodule

`default_nettype wire

// File: tb/tb_hive_stack_ring_p.sv
// ============================================================================
// tb_hive_stack_ring_p : scoreboard bench for hive_stack_ring_p against a
// queue-per-thread stack model.                              Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hive_stack_ring_p;
  localparam int THREADS = 8;
  localparam int DEPTH   = 32;
  localparam int DATA_W  = 33;
  localparam int THD_W   = 3;
  localparam int LVL_W   = 6;

  logic clk = 1'b0;
  logic rst_n;
  logic [THD_W-1:0]  id;
  logic              cls, pop, psh, pek;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] data_o;
  logic              vld_o;
  logic [LVL_W-1:0]  level_o;
  logic              pop_er_o, psh_er_o;

  always #5 clk = ~clk;

  hive_stack_ring_p #(.THREADS(THREADS), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .id_i(id), .cls_i(cls), .pop_i(pop),
    .psh_i(psh), .pek_i(pek), .data_i(din), .data_o(data_o), .vld_o(vld_o),
    .level_o(level_o), .pop_er_o(pop_er_o), .psh_er_o(psh_er_o)
  );

  typedef struct { int due; logic [LVL_W-1:0] lvl; logic pe; logic se; } s1_t;
  typedef struct { int due; logic vld; logic [DATA_W-1:0] d; } s2_t;

  s1_t q1[$];
  s2_t q2[$];
  logic [DATA_W-1:0] stk [THREADS][$];
  logic [DATA_W-1:0] last_d;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest due entry.
  always @(negedge clk) begin
    s1_t e1;
    s2_t e2;
    if (rst_n) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e1 = q1.pop_front();
        chk("level_o", 64'(level_o), 64'(e1.lvl));
        chk("pop_er_o", 64'(pop_er_o), 64'(e1.pe));
        chk("psh_er_o", 64'(psh_er_o), 64'(e1.se));
      end
      if (q2.size() > 0 && q2[0].due == cyc) begin
        e2 = q2.pop_front();
        chk("vld_o", 64'(vld_o), 64'(e2.vld));
        if (e2.vld) last_d = e2.d;
        chk("data_o", 64'(data_o), 64'(last_d));
      end
    end
  end

  task automatic req(input int t, input logic c, input logic po, input logic pu,
                     input logic pk, input logic [DATA_W-1:0] d);
    int L;
    logic v, pe, se;
    logic [DATA_W-1:0] rd;
    s1_t e1;
    s2_t e2;
    @(posedge clk);
    #1;
    id = THD_W'(t); cls = c; pop = po; psh = pu; pek = pk; din = d;
    L = stk[t].size();
    v = 1'b0; pe = 1'b0; se = 1'b0; rd = '0;
    if (c) begin
      stk[t].delete();
      if (pu) stk[t].push_back(d);
    end else if (po && pu) begin
      if (L > 0) begin
        rd = stk[t][L-1];
        stk[t][L-1] = d;
        v = 1'b1;
      end else begin
        pe = 1'b1;
        stk[t].push_back(d);
      end
    end else if (po) begin
      if (L > 0) begin
        rd = stk[t].pop_back();
        v = 1'b1;
      end else begin
        pe = 1'b1;
      end
    end else if (pu) begin
      if (L < DEPTH) stk[t].push_back(d);
      else se = 1'b1;
    end else if (pk) begin
`ifdef HIVE_STK_PEEK_EN
      if (L > 0) begin
        rd = stk[t][L-1];
        v = 1'b1;
      end else begin
        pe = 1'b1;
      end
`endif
    end
    e1.due = cyc + 1; e1.lvl = LVL_W'(stk[t].size()); e1.pe = pe; e1.se = se;
    e2.due = cyc + 2; e2.vld = v; e2.d = rd;
    q1.push_back(e1);
    q2.push_back(e2);
  endtask

  task automatic idle();
    req(0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic push(input int t, input logic [DATA_W-1:0] d);
    req(t, 1'b0, 1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic popr(input int t);
    req(t, 1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic check_reset_outputs();
    chk("rst data_o", 64'(data_o), 64'd0);
    chk("rst vld_o", 64'(vld_o), 64'd0);
    chk("rst level_o", 64'(level_o), 64'd0);
    chk("rst pop_er_o", 64'(pop_er_o), 64'd0);
    chk("rst psh_er_o", 64'(psh_er_o), 64'd0);
  endtask

  // Reset lands while the last request's read is still in flight.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    cls = 1'b0; pop = 1'b0; psh = 1'b0; pek = 1'b0;
    q1.delete();
    q2.delete();
    for (int t = 0; t < THREADS; t++) stk[t].delete();
    last_d = '0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] rr;
    int t;
    int r;
    logic c, po, pu, pk;
    rst_n = 1'b0; id = '0; cls = 1'b0; pop = 1'b0; psh = 1'b0; pek = 1'b0; din = '0;
    last_d = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LIFO order on thread 5
    push(5, 33'h1); push(5, 33'h2); push(5, 33'h3);
    popr(5); popr(5); popr(5);

    // Fill thread 0, overflow, then pop the genuine top
    for (int i = 0; i < DEPTH; i++) push(0, 33'(32'h100 + i));
    push(0, 33'h1FF);
    popr(0);

    // Pop on empty thread 3
    popr(3);

    // Replace on thread 2 at level 4
    push(2, 33'h7); push(2, 33'h8); push(2, 33'h9); push(2, 33'hA);
    req(2, 1'b0, 1'b1, 1'b1, 1'b0, 33'hB);
    popr(2);
    req(6, 1'b0, 1'b1, 1'b1, 1'b0, 33'hC);

    // Interleaved threads 0/1 with clear+push on thread 1
    push(0, 33'h10); push(1, 33'h20); push(0, 33'h11); push(1, 33'h21);
    popr(0); popr(1);
    req(1, 1'b1, 1'b1, 1'b1, 1'b0, 33'h7);
    popr(0); popr(1); popr(1);
    req(3, 1'b1, 1'b0, 1'b0, 1'b0, '0);

    // Peek on thread 4, then on an empty thread
    push(4, 33'h54); push(4, 33'h55);
    req(4, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    popr(4);
    req(7, 1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      t  = (i < 700) ? $urandom_range(0, 1) : $urandom_range(0, THREADS - 1);
      r  = $urandom_range(0, 99);
      c  = (r < 4);
      po = ($urandom_range(0, 99) < 40);
      pu = ($urandom_range(0, 99) < 55);
      pk = ($urandom_range(0, 99) < 20);
      rr = {$urandom(), $urandom()};
      req(t, c, po, pu, pk, rr[DATA_W-1:0]);
    end

    // Reset with a pop in flight, then confirm stacks are empty
    push(6, 33'h66);
    popr(6);
    mid_reset();
    idle(); idle();
    for (int k = 0; k < THREADS; k++) popr(k);
    push(6, 33'h99);
    popr(6);

    repeat (3) idle();
    repeat (4) @(posedge clk);
    chk("q1 drained", 64'(q1.size()), 64'd0);
    chk("q2 drained", 64'(q2.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
